// File: rtl/nrzi_unstuff_decoder_pkg.sv
// usb_rx_pkg: shared types and constants for the USB RX line decoder
package usb_rx_pkg;
  typedef enum logic [1:0] {IDLE, SE0_1, SE0_2} eop_state_t;
  localparam int USB_STUFF_LIMIT = 6;
  localparam logic USB_J_DPLUS = 1'b1;
endpackage

// File: rtl/nrzi_unstuff_decoder_if.sv
// nrzi_unstuff_decoder_if: line inputs and decoded-bit outputs of the RX decoder
interface nrzi_unstuff_decoder_if;
  logic d_plus_sync;
  logic d_minus_sync;
  logic shift_enable;
  logic clear;
  logic d_orig;
  logic d_valid;
  logic stuff_err;
  logic eop;
  logic se0_active;
  modport master (
    output d_plus_sync, d_minus_sync, shift_enable, clear,
    input  d_orig, d_valid, stuff_err, eop, se0_active
  );
  modport slave (
    input  d_plus_sync, d_minus_sync, shift_enable, clear,
    output d_orig, d_valid, stuff_err, eop, se0_active
  );
endinterface

// File: rtl/eop_detector.sv
// eop_detector: SE0-SE0-J end-of-packet FSM; eop flags the completing J strobe combinationally
module eop_detector
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic shift_enable,
  input  logic se0,
  input  logic is_j,
  output logic eop,
  output logic se0_active
);
  eop_state_t state_q, state_d;
  // state register; clear drops back to IDLE like reset
  always_ff @(posedge clk) begin
    if (rst || clear) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state on strobes; eop marks the J that closes an SE0 pair
  always_comb begin
    state_d = state_q;
    eop = 1'b0;
    if (shift_enable && !clear) begin
      state_d = se0 ? (state_q == IDLE ? SE0_1 : SE0_2) : IDLE;
      eop = (state_q == SE0_2) && is_j;
    end
  end
  assign se0_active = (state_q != IDLE);
endmodule

// File: rtl/nrzi_unstuff.sv
// nrzi_unstuff_decoder: NRZI decode, bit unstuffing and EOP detection for the USB RX path
module nrzi_unstuff_decoder
  import usb_rx_pkg::*;
#(
  parameter int   STUFF_LIMIT = USB_STUFF_LIMIT,
  parameter bit   NRZI_EN     = 1'b1,
  parameter logic IDLE_LEVEL  = USB_J_DPLUS
) (
  input logic clk,
  input logic rst,
  nrzi_unstuff_decoder_if.slave bus
);
  localparam int CW = $clog2(STUFF_LIMIT + 1);
  logic prev_lvl;
  logic [CW-1:0] ones_cnt;
  logic se0, is_j, b, eop_hit;
  assign se0 = !bus.d_plus_sync && !bus.d_minus_sync;
  assign is_j = (bus.d_plus_sync == IDLE_LEVEL) && (bus.d_minus_sync == !IDLE_LEVEL);
  assign b = NRZI_EN ? (bus.d_plus_sync == prev_lvl) : bus.d_plus_sync;
  eop_detector u_eop (
    .clk(clk),
    .rst(rst),
    .clear(bus.clear),
    .shift_enable(bus.shift_enable),
    .se0(se0),
    .is_j(is_j),
    .eop(eop_hit),
    .se0_active(bus.se0_active)
  );
  // per-strobe decode/unstuff; pulses default low so each lasts one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_lvl <= IDLE_LEVEL;
      ones_cnt <= '0;
      bus.d_orig <= 1'b1;
      bus.d_valid <= 1'b0;
      bus.stuff_err <= 1'b0;
      bus.eop <= 1'b0;
    end else begin
      bus.d_valid <= 1'b0;
      bus.stuff_err <= 1'b0;
      bus.eop <= 1'b0;
      if (bus.clear) begin
        prev_lvl <= IDLE_LEVEL;
        ones_cnt <= '0;
      end else if (bus.shift_enable) begin
        if (se0) begin
          prev_lvl <= IDLE_LEVEL;
          ones_cnt <= '0;
        end else begin
          prev_lvl <= bus.d_plus_sync;
          if (eop_hit) begin
            bus.eop <= 1'b1;
            ones_cnt <= '0;
          end else if (ones_cnt == CW'(STUFF_LIMIT)) begin
            bus.stuff_err <= b;
            ones_cnt <= '0;
          end else begin
            bus.d_orig <= b;
            bus.d_valid <= 1'b1;
            ones_cnt <= b ? ones_cnt + CW'(1) : '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_nrzi_unstuff_decoder.sv
// tb_nrzi_unstuff_decoder: randomized scoreboard bench for NRZI and bypass decoder instances
module tb_nrzi_unstuff_decoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  nrzi_unstuff_decoder_if bus0 ();
  nrzi_unstuff_decoder_if bus1 ();
  nrzi_unstuff_decoder u0 (.clk(clk), .rst(rst), .bus(bus0));
  nrzi_unstuff_decoder #(.NRZI_EN(1'b0)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  typedef logic [4:0] resp_t;
  resp_t q0[$];
  resp_t q1[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  bit started = 0;
  bit done = 0;
  logic m_ref[2];
  int m_ones[2];
  logic m_d[2];
  int run = 0;
  logic lvl = 1'b1;
  task automatic step(input logic dp, input logic dm, input logic se, input logic clr, input logic r);
    logic dv[2], er[2], eo[2];
    logic b, sa;
    bus0.d_plus_sync = dp; bus0.d_minus_sync = dm; bus0.shift_enable = se; bus0.clear = clr;
    bus1.d_plus_sync = dp; bus1.d_minus_sync = dm; bus1.shift_enable = se; bus1.clear = clr;
    rst = r;
    for (int n = 0; n < 2; n++) begin
      dv[n] = 0; er[n] = 0; eo[n] = 0;
      if (r) begin
        m_ref[n] = 1; m_ones[n] = 0; m_d[n] = 1;
      end else if (clr) begin
        m_ref[n] = 1; m_ones[n] = 0;
      end else if (se) begin
        if (!dp && !dm) begin
          m_ones[n] = 0; m_ref[n] = 1;
        end else begin
          b = (n == 1) ? dp : (dp == m_ref[n]);
          m_ref[n] = dp;
          if (run >= 2 && dp && !dm) begin
            eo[n] = 1; m_ones[n] = 0;
          end else if (m_ones[n] == 6) begin
            er[n] = b; m_ones[n] = 0;
          end else begin
            dv[n] = 1; m_d[n] = b; m_ones[n] = b ? m_ones[n] + 1 : 0;
          end
        end
      end
    end
    run = (r || clr) ? 0 : (se ? ((!dp && !dm) ? run + 1 : 0) : run);
    sa = (run > 0);
    q0.push_back({dv[0], er[0], eo[0], sa, m_d[0]});
    q1.push_back({dv[1], er[1], eo[1], sa, m_d[1]});
    started = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic tx_bit(input logic bit_v);
    if (!bit_v) lvl = ~lvl;
    step(lvl, ~lvl, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic line(input logic dp, input logic dm);
    step(dp, dm, 1'b1, 1'b0, 1'b0);
    if (!dp && !dm) lvl = 1'b1;
    else lvl = dp;
  endtask
  task automatic cmp(input string nm, input resp_t got, input resp_t exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc %0d got {dv,err,eop,se0a,d}=%b expected %b", nm, cyc, got, exp);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // scoreboard monitor: each cycle's registered outputs answer the oldest pending strobe
  initial begin
    forever begin
      @(negedge clk);
      if (started && !done) begin
        if (q0.size() > 0) cmp("nrzi", {bus0.d_valid, bus0.stuff_err, bus0.eop, bus0.se0_active, bus0.d_orig}, q0.pop_front());
        if (q1.size() > 0) cmp("bypass", {bus1.d_valid, bus1.stuff_err, bus1.eop, bus1.se0_active, bus1.d_orig}, q1.pop_front());
      end
    end
  end
  initial begin
    int r;
    logic se, clr, rr;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    lvl = 1'b1;
    repeat (5) tx_bit(1'b1);
    tx_bit(1'b0);
    foreach (q0[i]) ;
    for (int i = 0; i < 8; i++) tx_bit(i == 7);
    repeat (6) tx_bit(1'b1);
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(1'b0);
    repeat (7) tx_bit(1'b1);
    tx_bit(1'b0);
    tx_bit(1'b1);
    line(1'b0, 1'b0);
    line(1'b0, 1'b0);
    line(1'b1, 1'b0);
    tx_bit(1'b0);
    line(1'b0, 1'b0);
    line(1'b1, 1'b0);
    line(1'b0, 1'b0);
    line(1'b0, 1'b0);
    line(1'b0, 1'b0);
    line(1'b0, 1'b1);
    repeat (3) tx_bit(1'b1);
    step(~lvl, lvl, 1'b1, 1'b1, 1'b0);
    lvl = 1'b1;
    tx_bit(1'b0);
    tx_bit(1'b1);
    step(lvl, ~lvl, 1'b0, 1'b0, 1'b0);
    tx_bit(1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    lvl = 1'b1;
    repeat (4) tx_bit(1'b1);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      se = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 99) < 3);
      rr = ($urandom_range(0, 199) == 0);
      if (r < 8) begin
        step(1'b0, 1'b0, se, clr, rr);
        if (se) lvl = 1'b1;
      end else begin
        if (r >= 78) lvl = ~lvl;
        step(lvl, ~lvl, se, clr, rr);
      end
      if (rr || clr) lvl = 1'b1;
    end
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    done = 1;
    checks++;
    if (q0.size() == 0 && q1.size() == 0) passed++;
    else $display("FAIL drain got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
